pop_cycle_monitor: RTL
======================

# pop_cycle_monitor

Passive receiver for the POP timing outputs (pump, probe, MW, sample) produced by the POP timer block. Decodes each POP cycle into its phases and reports measured widths in clk_2M5 cycles, plus a protocol-error strobe. Sits beside the output registers in the top level, feeding debug/readback logic. It never drives the POP signals.

## Interface
- W, 16, width of every duration counter and result port
- clk_2M5  input  1  2.5 MHz system clock; all logic on posedge
- reset  input  1  asynchronous, active-high reset
- pump, probe, MW, sample  input  1 each  POP signals, synchronous to clk_2M5
- meas_valid  output  1  one-cycle strobe: all result ports below updated this cycle
- pump_width, mw1_width, freeprec_width, mw2_width, probe_width, sample_width  output  W each  last complete cycle's durations
- cycle_period  output  W  pump rise to next pump rise (see Configuration)
- err_valid  output  1  one-cycle strobe on protocol error
- err_code  output  2  1 TIMEOUT, 2 OVERLAP, 3 RESTART; holds last error
- cycle_count  output  16  completed good cycles, wraps at 65535 -> 0

## Operation
- Inputs registered once (x_q); edges from x_q vs previous x_q. All decisions use registered values.
- States: IDLE -> PUMP (pump_q rise) -> WAIT_MW1 (pump_q fall) -> MW1 (MW_q rise) -> FREEPREC (MW_q fall) -> MW2 (MW_q rise) -> WAIT_PROBE (MW_q fall) -> PROBE (probe_q rise) -> REPORT (probe_q fall) -> IDLE.
- Widths count registered-high cycles: pump in PUMP, MW in MW1/MW2, free precession = cycles in FREEPREC, probe in PROBE, sample_width = cycles with sample_q high while in PROBE.
- Counters saturate at 2^W-1; saturation in any non-IDLE state -> TIMEOUT, return to IDLE.
- OVERLAP: MW_q high while pump_q or probe_q high, or probe_q high in PUMP/MW1/MW2. -> IDLE.
- RESTART: pump_q rise in any state except IDLE/REPORT -> error, then enter PUMP directly (new cycle counted from that rise).
- On error: err_valid pulse, err_code updated, result ports and cycle_count unchanged.
- REPORT: latch all results, pulse meas_valid, cycle_count+1. A pump rise seen in REPORT goes to PUMP, no error.
- Simultaneous error conditions priority: RESTART > OVERLAP > TIMEOUT.

## Timing
- Reset: state IDLE; every output 0, err_code 0, counters 0.
- meas_valid asserts 2 clk_2M5 cycles after the first edge sampling probe low (1 input register + 1 REPORT).
- err_valid asserts 2 cycles after the offending input sample.
- Results stable between strobes. Reset mid-cycle discards the partial cycle; no strobe.
- Minimum phase length 1 cycle; zero-length FREEPREC (MW low one cycle) valid -> freeprec_width 1.

## Configuration
- POP_MON_PERIOD_EN defined: period counter runs from each pump_q rise (saturating), latched into cycle_period at the next pump_q rise after a good REPORT; first cycle after reset/error reports 0.
- Undefined: no period counter; cycle_period tied 0.

## Structure
- Shared package pop_pkg: state enum, err_code constants (ERR_NONE/TIMEOUT/OVERLAP/RESTART), default W.
- One sub-module: pop_edge_sync (input register plus rise/fall detect, one instance per signal).

## Test plan
- Nominal: pump 10, gap 5, MW 4, free 20, MW 4, gap 3, probe 8 with sample 6 -> meas_valid once, widths 10/4/20/4/8/6, cycle_count 1.
- Timeout (W=4): pump held high 20 cycles -> err_valid, err_code 1 at count 15, no meas_valid.
- Overlap: MW rises while pump high -> err_code 2, state IDLE, results unchanged.
- Restart: pump re-rises during FREEPREC -> err_code 3, following full cycle reported correctly.
- Reset asserted during MW2 -> all outputs 0 immediately; next nominal cycle reports cleanly.
- POP_MON_PERIOD_EN: two back-to-back cycles, 100-cycle pump spacing -> cycle_period 100 on second cycle; macro off -> 0.

Source files
------------

// File: rtl/pop_pkg.sv
// Shared definitions for the POP cycle monitor: FSM states, error codes, default width.
package pop_pkg;

    localparam int unsigned PopW = 16;

    typedef enum logic [3:0] {
        StIdle,
        StPump,
        StWaitMw1,
        StMw1,
        StFreePrec,
        StMw2,
        StWaitProbe,
        StProbe,
        StReport
    } pop_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_OVERLAP = 2'd2;
    localparam logic [1:0] ERR_RESTART = 2'd3;

    // True while a POP cycle is being tracked and protocol checks apply.
    function automatic logic in_cycle(input pop_state_e s);
        return (s != StIdle) && (s != StReport);
    endfunction

endpackage

// File: rtl/pop_edge_sync.sv
// Single-bit input register with rise/fall detection on the registered value.
module pop_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic q_q;
    logic prev_q;

    // Capture the input, then keep one cycle of history for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q    <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            q_q    <= d_i;
            prev_q <= q_q;
        end
    end

    assign q_o    = q_q;
    assign rise_o = q_q & ~prev_q;
    assign fall_o = ~q_q & prev_q;

endmodule

// File: rtl/pop_cycle_monitor.sv
// Passive POP cycle monitor: decodes pump/MW/probe/sample into phase widths and
// flags protocol errors. Optional macro POP_MON_PERIOD_EN enables the
// pump-to-pump period measurement; otherwise cycle_period_o is tied to zero.
module pop_cycle_monitor
    import pop_pkg::*;
#(
    parameter int unsigned W = PopW
) (
    input  logic         clk_2m5_i,
    input  logic         reset_i,
    input  logic         pump_i,
    input  logic         probe_i,
    input  logic         mw_i,
    input  logic         sample_i,
    output logic         meas_valid_o,
    output logic [W-1:0] pump_width_o,
    output logic [W-1:0] mw1_width_o,
    output logic [W-1:0] freeprec_width_o,
    output logic [W-1:0] mw2_width_o,
    output logic [W-1:0] probe_width_o,
    output logic [W-1:0] sample_width_o,
    output logic [W-1:0] cycle_period_o,
    output logic         err_valid_o,
    output logic [1:0]   err_code_o,
    output logic [15:0]  cycle_count_o
);

    localparam logic [W-1:0] CntMax = '1;
    localparam logic [W-1:0] CntOne = {{(W-1){1'b0}}, 1'b1};

    logic pump_q, pump_rise, pump_fall;
    logic probe_q, probe_rise, probe_fall;
    logic mw_q, mw_rise, mw_fall;
    logic sample_q, sample_rise, sample_fall;

    pop_edge_sync u_pump (
        .clk_i (clk_2m5_i), .rst_i (reset_i), .d_i (pump_i),
        .q_o   (pump_q), .rise_o (pump_rise), .fall_o (pump_fall)
    );
    pop_edge_sync u_probe (
        .clk_i (clk_2m5_i), .rst_i (reset_i), .d_i (probe_i),
        .q_o   (probe_q), .rise_o (probe_rise), .fall_o (probe_fall)
    );
    pop_edge_sync u_mw (
        .clk_i (clk_2m5_i), .rst_i (reset_i), .d_i (mw_i),
        .q_o   (mw_q), .rise_o (mw_rise), .fall_o (mw_fall)
    );
    pop_edge_sync u_sample (
        .clk_i (clk_2m5_i), .rst_i (reset_i), .d_i (sample_i),
        .q_o   (sample_q), .rise_o (sample_rise), .fall_o (sample_fall)
    );

    logic unused_edges;
    assign unused_edges = sample_rise ^ sample_fall;

    pop_state_e   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [W-1:0] samp_q, samp_d;
    logic [W-1:0] pump_w_q, pump_w_d, mw1_w_q, mw1_w_d, free_w_q, free_w_d;
    logic [W-1:0] mw2_w_q, mw2_w_d, probe_w_q, probe_w_d;
    logic         err_pend_q, err_pend_d;
    logic [1:0]   err_pend_code_q, err_pend_code_d;
    logic         cyc_start, tmo, restart, overlap, report, err_any, cnt_sat;

    assign cnt_sat = (cnt_q == CntMax);
    assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CntOne;
    assign report  = (state_q == StReport);
    assign restart = pump_rise & in_cycle(state_q);
    assign overlap = in_cycle(state_q) &
                     ((mw_q & (pump_q | probe_q)) |
                      (probe_q & ((state_q == StPump) || (state_q == StMw1) ||
                                  (state_q == StMw2))));
    assign err_any = err_pend_d;

    // Next-state, phase counters and error selection (RESTART > OVERLAP > TIMEOUT).
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        samp_d          = samp_q;
        pump_w_d        = pump_w_q;
        mw1_w_d         = mw1_w_q;
        free_w_d        = free_w_q;
        mw2_w_d         = mw2_w_q;
        probe_w_d       = probe_w_q;
        err_pend_d      = 1'b0;
        err_pend_code_d = ERR_NONE;
        cyc_start       = 1'b0;
        tmo             = 1'b0;
        // A phase counter is loaded with 1 on entry: the cycle that showed the edge counts.
        case (state_q)
            StIdle: begin
                if (pump_rise) begin
                    state_d   = StPump;
                    cnt_d     = CntOne;
                    cyc_start = 1'b1;
                end
            end
            StPump: begin
                if (pump_fall) begin
                    state_d  = StWaitMw1;
                    pump_w_d = cnt_q;
                    cnt_d    = CntOne;
                end else begin
                    cnt_d = cnt_inc;
                    tmo   = cnt_sat;
                end
            end
            StWaitMw1: begin
                if (mw_rise) begin
                    state_d = StMw1;
                    cnt_d   = CntOne;
                end else begin
                    cnt_d = cnt_inc;
                    tmo   = cnt_sat;
                end
            end
            StMw1: begin
                if (mw_fall) begin
                    state_d = StFreePrec;
                    mw1_w_d = cnt_q;
                    cnt_d   = CntOne;
                end else begin
                    cnt_d = cnt_inc;
                    tmo   = cnt_sat;
                end
            end
            StFreePrec: begin
                if (mw_rise) begin
                    state_d  = StMw2;
                    free_w_d = cnt_q;
                    cnt_d    = CntOne;
                end else begin
                    cnt_d = cnt_inc;
                    tmo   = cnt_sat;
                end
            end
            StMw2: begin
                if (mw_fall) begin
                    state_d = StWaitProbe;
                    mw2_w_d = cnt_q;
                    cnt_d   = CntOne;
                end else begin
                    cnt_d = cnt_inc;
                    tmo   = cnt_sat;
                end
            end
            StWaitProbe: begin
                if (probe_rise) begin
                    state_d = StProbe;
                    cnt_d   = CntOne;
                    samp_d  = {{(W-1){1'b0}}, sample_q};
                end else begin
                    cnt_d = cnt_inc;
                    tmo   = cnt_sat;
                end
            end
            StProbe: begin
                if (probe_fall) begin
                    state_d   = StReport;
                    probe_w_d = cnt_q;
                end else begin
                    cnt_d  = cnt_inc;
                    samp_d = samp_q + {{(W-1){1'b0}}, sample_q};
                    tmo    = cnt_sat;
                end
            end
            StReport: begin
                if (pump_rise) begin
                    state_d   = StPump;
                    cnt_d     = CntOne;
                    cyc_start = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (restart) begin
            state_d         = StPump;
            cnt_d           = CntOne;
            cyc_start       = 1'b1;
            err_pend_d      = 1'b1;
            err_pend_code_d = ERR_RESTART;
        end else if (overlap) begin
            state_d         = StIdle;
            cnt_d           = '0;
            err_pend_d      = 1'b1;
            err_pend_code_d = ERR_OVERLAP;
        end else if (tmo) begin
            state_d         = StIdle;
            cnt_d           = '0;
            err_pend_d      = 1'b1;
            err_pend_code_d = ERR_TIMEOUT;
        end
    end

    // FSM state, working counters and per-phase width shadows.
    always_ff @(posedge clk_2m5_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            samp_q          <= '0;
            pump_w_q        <= '0;
            mw1_w_q         <= '0;
            free_w_q        <= '0;
            mw2_w_q         <= '0;
            probe_w_q       <= '0;
            err_pend_q      <= 1'b0;
            err_pend_code_q <= ERR_NONE;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            samp_q          <= samp_d;
            pump_w_q        <= pump_w_d;
            mw1_w_q         <= mw1_w_d;
            free_w_q        <= free_w_d;
            mw2_w_q         <= mw2_w_d;
            probe_w_q       <= probe_w_d;
            err_pend_q      <= err_pend_d;
            err_pend_code_q <= err_pend_code_d;
        end
    end

    logic         meas_valid_q, err_valid_q;
    logic [1:0]   err_code_q;
    logic [15:0]  cycle_count_q;
    logic [W-1:0] pump_width_q, mw1_width_q, freeprec_width_q, mw2_width_q;
    logic [W-1:0] probe_width_q, sample_width_q;

    // Publish results in REPORT; errors leave results and the count untouched.
    always_ff @(posedge clk_2m5_i or posedge reset_i) begin
        if (reset_i) begin
            meas_valid_q     <= 1'b0;
            err_valid_q      <= 1'b0;
            err_code_q       <= ERR_NONE;
            cycle_count_q    <= '0;
            pump_width_q     <= '0;
            mw1_width_q      <= '0;
            freeprec_width_q <= '0;
            mw2_width_q      <= '0;
            probe_width_q    <= '0;
            sample_width_q   <= '0;
        end else begin
            meas_valid_q <= report;
            err_valid_q  <= err_pend_q;
            if (err_pend_q) begin
                err_code_q <= err_pend_code_q;
            end
            if (report) begin
                cycle_count_q    <= cycle_count_q + 16'd1;
                pump_width_q     <= pump_w_q;
                mw1_width_q      <= mw1_w_q;
                freeprec_width_q <= free_w_q;
                mw2_width_q      <= mw2_w_q;
                probe_width_q    <= probe_w_q;
                sample_width_q   <= samp_q;
            end
        end
    end

    assign meas_valid_o     = meas_valid_q;
    assign err_valid_o      = err_valid_q;
    assign err_code_o       = err_code_q;
    assign cycle_count_o    = cycle_count_q;
    assign pump_width_o     = pump_width_q;
    assign mw1_width_o      = mw1_width_q;
    assign freeprec_width_o = freeprec_width_q;
    assign mw2_width_o      = mw2_width_q;
    assign probe_width_o    = probe_width_q;
    assign sample_width_o   = sample_width_q;

`ifdef POP_MON_PERIOD_EN
    logic [W-1:0] per_cnt_q, per_shadow_q, cycle_period_q;
    logic         arm_q;

    // Period runs from each cycle start; the snapshot is valid only after a good REPORT.
    always_ff @(posedge clk_2m5_i or posedge reset_i) begin
        if (reset_i) begin
            per_cnt_q      <= '0;
            per_shadow_q   <= '0;
            cycle_period_q <= '0;
            arm_q          <= 1'b0;
        end else begin
            per_cnt_q <= (per_cnt_q == CntMax) ? per_cnt_q : per_cnt_q + CntOne;
            if (report) begin
                cycle_period_q <= per_shadow_q;
                arm_q          <= 1'b1;
            end
            if (err_any) begin
                arm_q <= 1'b0;
            end
            // A start in REPORT is back-to-back with the good cycle just finished.
            if (cyc_start) begin
                per_cnt_q    <= CntOne;
                per_shadow_q <= (arm_q | report) ? per_cnt_q : '0;
                arm_q        <= 1'b0;
            end
        end
    end

    assign cycle_period_o = cycle_period_q;
`else
    logic unused_period;
    assign unused_period  = cyc_start ^ err_any;
    assign cycle_period_o = '0;
`endif

endmodule
